// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - 32-bit down-counting timer with one-shot/auto-reload modes and masked IRQ
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        auto_reload;

    assign ctrl_wr     = WE && (Addr == 2'd0);
    assign preset_wr   = WE && (Addr == 2'd1);
    assign auto_reload = (ctrl[2:1] == 2'b01);

    // Later assignments win: a hardware flag set overrides the software clear,
    // and the INT-state Enable clear is skipped when software writes CTRL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            if (preset_wr) begin
                preset <= Din;
            end
            if (ctrl_wr) begin
                ctrl     <= Din[3:0];
                irq_flag <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (ctrl[0]) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!ctrl[0]) begin
                        state <= S_IDLE;
                    end else begin
                        count <= preset;
                        state <= S_CNT;
                    end
                end
                S_CNT: begin
                    if (!ctrl[0]) begin
                        state <= S_IDLE;
                    end else if (count <= 32'd1) begin
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= S_INT;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                S_INT: begin
                    if (auto_reload) begin
                        irq_flag <= 1'b0;
                        state    <= S_LOAD;
                    end else begin
                        if (!ctrl_wr) begin
                            ctrl[0] <= 1'b0;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr)
            2'd0:    Dout = {28'd0, ctrl};
            2'd1:    Dout = preset;
            2'd2:    Dout = count;
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag & ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - scoreboard bench for timer_counter
`timescale 1ns/1ps
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    // kind 0..3 reads Dout at that address, kind 4 samples IRQ
    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int kind, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.kind  = kind;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == 4) begin
                check(e.tag, {31'd0, IRQ}, e.value);
            end else begin
                Addr = e.kind[1:0];
                #1;
                check(e.tag, Dout, e.value);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = 2'd0;
        Din   = 32'd0;
        #4;
        for (int a = 0; a < 4; a++) push("reset_dout", a, 32'd0);
        push("reset_irq", 4, 32'd0);
        drain();
        reset = 1'b0;

        // one-shot, P = 5
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            if (k >= 2) push("os_count", 2, (k <= 7) ? 32'(5 - (k - 2)) : 32'd0);
            push("os_irq", 4, (k >= 7) ? 32'd1 : 32'd0);
            tick();
            drain();
        end
        push("os_ctrl_after", 0, 32'h8);
        push("os_irq_hold", 4, 32'd1);
        tick();
        tick();
        drain();

        // software clear of the flag with IM still set
        wr(2'd0, 32'h8);
        push("clr_irq", 4, 32'd0);
        drain();
        for (int k = 0; k < 3; k++) begin
            push("clr_idle_irq", 4, 32'd0);
            push("clr_idle_count", 2, 32'd0);
            tick();
            drain();
        end

        // auto-reload, P = 3, period 5
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            int m;
            m = (k - 2) % 5;
            if (k >= 2) begin
                push("ar_count", 2, (m <= 2) ? 32'(3 - m) : 32'd0);
                push("ar_irq", 4, (m == 3) ? 32'd1 : 32'd0);
            end
            tick();
            drain();
        end
        wr(2'd0, 32'h0);
        pulse_reset();

        // PRESET = 0 behaves like 1, IM = 0 hides the flag
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        tick();
        tick();
        push("p0_count", 2, 32'd0);
        push("p0_irq_masked", 4, 32'd0);
        tick();
        drain();
        pulse_reset();

        // CTRL write lands on the same edge as the hardware set
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        tick();
        tick();
        wr(2'd0, 32'h8);
        push("coll_irq", 4, 32'd1);
        push("coll_ctrl", 0, 32'h8);
        drain();
        for (int k = 0; k < 3; k++) begin
            push("coll_irq_hold", 4, 32'd1);
            tick();
            drain();
        end
        pulse_reset();

        // disable mid-count, then re-enable restarts through LOAD
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) tick();
        push("dis_pre_count", 2, 32'd7);
        drain();
        wr(2'd0, 32'h8);
        push("dis_count", 2, 32'd6);
        drain();
        for (int k = 0; k < 3; k++) begin
            push("dis_hold_count", 2, 32'd6);
            push("dis_irq", 4, 32'd0);
            tick();
            drain();
        end
        wr(2'd0, 32'h9);
        tick();
        push("re_load_count", 2, 32'd6);
        drain();
        tick();
        push("re_count_p", 2, 32'd10);
        drain();
        tick();
        push("re_count_p1", 2, 32'd9);
        drain();
        pulse_reset();

        // asynchronous reset while IRQ is high
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 4; k++) tick();
        push("ar_pre_irq", 4, 32'd1);
        drain();
        #1 reset = 1'b1;
        #1;
        push("async_irq", 4, 32'd0);
        for (int a = 0; a < 4; a++) push("async_dout", a, 32'd0);
        drain();
        #2 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push("post_rst_irq", 4, 32'd0);
            push("post_rst_count", 2, 32'd0);
            tick();
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
